dsp_t1_fir_sequencer: RTL

//  Drives one dsp_t1_20x18x64 MAC slice as an NTAPS-tap FIR filter. It is the issuing end of the DSP operand/control interface.

---
 rtl/dsp_t1_fir_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dsp_t1_fir_sequencer.sv
// dsp_t1_fir_sequencer
// Sequences one dsp_t1_20x18x64 MAC slice as an NTAPS-tap FIR filter.
// Samples arrive on a valid/ready stream, each tap is issued to the slice on
// its own cycle, and the accumulated result is returned on an output stream.
// Optional feature macro: DSP_FIR_SEQ_ROUND_SAT_EN (drives round/saturate/shift
// to the slice while a filter pass is in flight).
module dsp_t1_fir_sequencer #(
    parameter int NTAPS   = 8,
    parameter int DSP_LAT = 1,
    parameter int SHIFT   = 0
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [19:0] s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic        coeff_wr_i,
    input  logic [3:0]  coeff_addr_i,
    input  logic [17:0] coeff_data_i,
    output logic [37:0] m_data_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [19:0] dsp_a_o,
    output logic [17:0] dsp_b_o,
    output logic        dsp_load_acc_o,
    output logic [2:0]  dsp_feedback_o,
    output logic [2:0]  dsp_output_select_o,
    output logic [5:0]  dsp_shift_right_o,
    output logic        dsp_round_o,
    output logic        dsp_saturate_enable_o,
    output logic        dsp_subtract_o,
    output logic        dsp_unsigned_a_o,
    output logic        dsp_unsigned_b_o,
    output logic        dsp_register_inputs_o,
    input  logic [37:0] dsp_z_i
);

    localparam int KW = $clog2(NTAPS);
    localparam int CW = (DSP_LAT > 1) ? $clog2(DSP_LAT + 1) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NTAPS - 1);
    localparam logic [CW-1:0] CLOAD = CW'(DSP_LAT);

    if (NTAPS < 2 || NTAPS > 16) begin : g_chk_ntaps
        $error("NTAPS must be within 2..16");
    end
    if (DSP_LAT < 1) begin : g_chk_lat
        $error("DSP_LAT must be at least 1");
    end
    if (SHIFT < 0 || SHIFT > 63) begin : g_chk_shift
        $error("SHIFT must be within 0..63");
    end

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q;
    logic [CW-1:0] cnt_q;
    logic [19:0]   x_q [NTAPS];
    logic [17:0]   h_q [NTAPS];
    logic [37:0]   m_data_q;
    logic          m_valid_q;
    logic          s_ready_q;
    logic          accept;
    logic          coeff_we;

    assign accept   = s_valid_i & s_ready_q;
    assign coeff_we = coeff_wr_i && (state_q == IDLE)
                      && ({28'd0, coeff_addr_i} < 32'(NTAPS));

    // State register
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic: one pass is IDLE -> MAC x NTAPS -> DRAIN -> OUT
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept)            state_d = MAC;
            MAC:   if (k_q == KLAST)      state_d = DRAIN;
            DRAIN: if (cnt_q == '0)       state_d = OUT;
            OUT:   if (m_ready_i)         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Datapath: delay line, coefficient bank, tap index, latency counter, result
    // s_ready is registered from the next state so it stays low through reset
    // and rises on the first edge after release.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < 32'(NTAPS); i++) begin
                x_q[i] <= '0;
                h_q[i] <= '0;
            end
            k_q       <= '0;
            cnt_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            s_ready_q <= (state_d == IDLE);
            if (coeff_we) h_q[coeff_addr_i[KW-1:0]] <= coeff_data_i;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        for (int unsigned i = 1; i < 32'(NTAPS); i++) x_q[i] <= x_q[i-1];
                        x_q[0] <= s_data_i;
                        k_q    <= '0;
                    end
                end
                MAC: begin
                    if (k_q == KLAST) cnt_q <= CLOAD;
                    else              k_q   <= k_q + KW'(1);
                end
                DRAIN: begin
                    if (cnt_q == '0) begin
                        m_data_q  <= dsp_z_i;
                        m_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                OUT: if (m_ready_i) m_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Output decode: slice operands and controls from the current state
    always_comb begin
        dsp_a_o               = '0;
        dsp_b_o               = '0;
        dsp_load_acc_o        = 1'b0;
        dsp_feedback_o        = 3'd0;
        dsp_round_o           = 1'b0;
        dsp_saturate_enable_o = 1'b0;
        dsp_shift_right_o     = '0;
        if (state_q == MAC) begin
            dsp_a_o        = x_q[k_q];
            dsp_b_o        = h_q[k_q];
            dsp_load_acc_o = 1'b1;
            dsp_feedback_o = (k_q == '0) ? 3'd1 : 3'd0;
        end
`ifdef DSP_FIR_SEQ_ROUND_SAT_EN
        if (state_q == MAC || state_q == DRAIN) begin
            dsp_round_o           = 1'b1;
            dsp_saturate_enable_o = 1'b1;
            dsp_shift_right_o     = 6'(SHIFT);
        end
`endif
    end

    assign s_ready_o             = s_ready_q;
    assign m_data_o              = m_data_q;
    assign m_valid_o             = m_valid_q;
    assign dsp_output_select_o   = 3'd1;
    assign dsp_subtract_o        = 1'b0;
    assign dsp_unsigned_a_o      = 1'b0;
    assign dsp_unsigned_b_o      = 1'b0;
    assign dsp_register_inputs_o = 1'b0;

endmodule
